nonrd_div_param: RTL and testbench

Parametrised non-restoring divider: divides a 2·WIDTH-bit dividend by a WIDTH-bit divisor and returns a WIDTH-bit quotient and remainder, one quotient bit per clock. It succeeds the fixed 16-bit divider in the arithmetic unit. Additions over that divider: configurable width, valid/ready handshakes on both word buses, an optional signed mode, and divide-by-zero and overflow detection. Operands are loaded and results unloaded as words over shared multiplexed buses, as elsewhere in the ALU.

---
 rtl/nonrd_div_param_if.sv | 26 ++
 rtl/nonrd_div_param.sv | 216 +++++++++++++++++++++
 tb/tb_nonrd_div_param.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/nonrd_div_param_if.sv
// Word-bus bundle for the non-restoring divider: operand load bus in, result unload bus out.
// The divider connects through the slave modport; a driver or bench uses master.
interface nonrd_div_param_if #(
    parameter int WIDTH = 16
);
    logic [WIDTH-1:0] inbus;
    logic             in_valid;
    logic             in_ready;
    logic             signed_mode;
    logic [WIDTH-1:0] outbus;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             div_by_zero;
    logic             overflow;

    modport master (
        output inbus, in_valid, signed_mode, out_ready,
        input  in_ready, outbus, out_valid, busy, div_by_zero, overflow
    );

    modport slave (
        input  inbus, in_valid, signed_mode, out_ready,
        output in_ready, outbus, out_valid, busy, div_by_zero, overflow
    );
endinterface

// File: rtl/nonrd_div_param.sv
// Parametrised non-restoring divider, 2*WIDTH / WIDTH -> WIDTH quotient and remainder, one bit per clock.
// Optional two's-complement mode is compiled in when NRD_SIGNED_EN is defined.
module nonrd_div_param #(
    parameter int WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    nonrd_div_param_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [3:0] LD_HI   = 4'd0;
    localparam logic [3:0] LD_LO   = 4'd1;
    localparam logic [3:0] LD_M    = 4'd2;
    localparam logic [3:0] CHECK   = 4'd3;
    localparam logic [3:0] ITER    = 4'd4;
    localparam logic [3:0] CORRECT = 4'd5;
    localparam logic [3:0] SIGN    = 4'd6;
    localparam logic [3:0] OUT_Q   = 4'd7;
    localparam logic [3:0] OUT_R   = 4'd8;

    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] Q_SAT    = {WIDTH{1'b1}};

    logic [3:0]       state_reg, state_next;
    logic [WIDTH-1:0] hi_reg, lo_reg, m_reg;
    logic [WIDTH:0]   acc_reg;
    logic [WIDTH-1:0] q_reg;
    logic [CW-1:0]    cnt_reg;
    logic             exc_reg, dbz_reg, ovf_reg;
    logic [WIDTH-1:0] outbus_reg;
    logic             out_valid_reg, busy_reg, div_by_zero_reg, overflow_reg;

    logic             in_ready;
    logic             word_fire;
    logic [2*WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] m_mag;
    logic [WIDTH-1:0] hi_mag, lo_mag;
    logic             m_zero, hi_ge;
    logic [WIDTH:0]   shifted, acc_step, acc_fix;
    logic [WIDTH-1:0] q_fin, r_fin;
    logic             sign_ovf;

    assign in_ready  = (state_reg == LD_HI) || (state_reg == LD_LO) || (state_reg == LD_M);
    assign word_fire = bus.in_valid && in_ready;

`ifdef NRD_SIGNED_EN
    logic               sgn_reg;
    logic               dvd_neg, m_neg, q_neg;
    logic [2*WIDTH-1:0] dvd_raw;
    logic [WIDTH-1:0]   q_limit;

    assign dvd_raw = {hi_reg, lo_reg};
    assign dvd_neg = sgn_reg & hi_reg[WIDTH-1];
    assign m_neg   = sgn_reg & m_reg[WIDTH-1];
    assign q_neg   = dvd_neg ^ m_neg;
    assign dvd_mag = dvd_neg ? -dvd_raw : dvd_raw;
    assign m_mag   = m_neg ? -m_reg : m_reg;
    // Largest legal quotient magnitude: 2^(W-1) if negative, 2^(W-1)-1 if positive.
    assign q_limit = q_neg ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};

    always_comb begin
        q_fin    = q_reg;
        r_fin    = acc_reg[WIDTH-1:0];
        sign_ovf = 1'b0;
        if (sgn_reg && !exc_reg) begin
            sign_ovf = (q_reg > q_limit);
            if (q_neg) begin
                q_fin = -q_reg;
            end
            if (dvd_neg) begin
                r_fin = -acc_reg[WIDTH-1:0];
            end
            if (sign_ovf) begin
                q_fin = Q_SAT;
                r_fin = '0;
            end
        end
    end
`else
    logic signed_mode_unused;

    assign signed_mode_unused = bus.signed_mode;
    assign dvd_mag  = {hi_reg, lo_reg};
    assign m_mag    = m_reg;
    assign q_fin    = q_reg;
    assign r_fin    = acc_reg[WIDTH-1:0];
    assign sign_ovf = 1'b0;
`endif

    assign hi_mag = dvd_mag[2*WIDTH-1:WIDTH];
    assign lo_mag = dvd_mag[WIDTH-1:0];
    assign m_zero = (m_reg == '0);
    assign hi_ge  = (hi_mag >= m_mag);

    // {S,A} is a (W+1)-bit signed partial remainder; wrap-around in the shift is harmless
    // because the add/sub result always lands back in [-M, M).
    assign shifted  = {acc_reg[WIDTH-1:0], q_reg[WIDTH-1]};
    assign acc_step = acc_reg[WIDTH] ? (shifted + {1'b0, m_mag}) : (shifted - {1'b0, m_mag});
    assign acc_fix  = acc_reg + {1'b0, m_mag};

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            LD_HI:   if (word_fire) state_next = LD_LO;
            LD_LO:   if (word_fire) state_next = LD_M;
            LD_M:    if (word_fire) state_next = CHECK;
            // Exceptions borrow the SIGN slot so their results surface two edges after the divisor.
            CHECK:   state_next = (m_zero || hi_ge) ? SIGN : ITER;
            ITER:    if (cnt_reg == '0) state_next = CORRECT;
            CORRECT: state_next = SIGN;
            SIGN:    state_next = OUT_Q;
            OUT_Q:   if (bus.out_ready) state_next = OUT_R;
            OUT_R:   if (bus.out_ready) state_next = LD_HI;
            default: state_next = LD_HI;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg       <= LD_HI;
            hi_reg          <= '0;
            lo_reg          <= '0;
            m_reg           <= '0;
            acc_reg         <= '0;
            q_reg           <= '0;
            cnt_reg         <= '0;
            exc_reg         <= 1'b0;
            dbz_reg         <= 1'b0;
            ovf_reg         <= 1'b0;
            outbus_reg      <= '0;
            out_valid_reg   <= 1'b0;
            busy_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
            overflow_reg    <= 1'b0;
`ifdef NRD_SIGNED_EN
            sgn_reg         <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            case (state_reg)
                LD_HI: begin
                    if (word_fire) begin
                        hi_reg   <= bus.inbus;
                        busy_reg <= 1'b1;
`ifdef NRD_SIGNED_EN
                        sgn_reg  <= bus.signed_mode;
`endif
                    end
                end
                LD_LO: begin
                    if (word_fire) lo_reg <= bus.inbus;
                end
                LD_M: begin
                    if (word_fire) m_reg <= bus.inbus;
                end
                CHECK: begin
                    if (m_zero) begin
                        dbz_reg <= 1'b1;
                        exc_reg <= 1'b1;
                        q_reg   <= Q_SAT;
                        acc_reg <= {1'b0, lo_reg};
                    end else if (hi_ge) begin
                        ovf_reg <= 1'b1;
                        exc_reg <= 1'b1;
                        q_reg   <= Q_SAT;
                        acc_reg <= '0;
                    end else begin
                        acc_reg <= {1'b0, hi_mag};
                        q_reg   <= lo_mag;
                        cnt_reg <= CNT_INIT;
                    end
                end
                ITER: begin
                    acc_reg <= acc_step;
                    q_reg   <= {q_reg[WIDTH-2:0], ~acc_step[WIDTH]};
                    cnt_reg <= cnt_reg - 1'b1;
                end
                CORRECT: begin
                    if (acc_reg[WIDTH]) acc_reg <= acc_fix;
                end
                SIGN: begin
                    outbus_reg      <= q_fin;
                    acc_reg         <= {1'b0, r_fin};
                    out_valid_reg   <= 1'b1;
                    div_by_zero_reg <= dbz_reg;
                    overflow_reg    <= ovf_reg | sign_ovf;
                end
                OUT_Q: begin
                    if (bus.out_ready) outbus_reg <= acc_reg[WIDTH-1:0];
                end
                OUT_R: begin
                    if (bus.out_ready) begin
                        outbus_reg      <= '0;
                        out_valid_reg   <= 1'b0;
                        busy_reg        <= 1'b0;
                        div_by_zero_reg <= 1'b0;
                        overflow_reg    <= 1'b0;
                        dbz_reg         <= 1'b0;
                        ovf_reg         <= 1'b0;
                        exc_reg         <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.outbus      = outbus_reg;
    assign bus.out_valid   = out_valid_reg;
    assign bus.busy        = busy_reg;
    assign bus.div_by_zero = div_by_zero_reg;
    assign bus.overflow    = overflow_reg;

endmodule

// File: tb/tb_nonrd_div_param.sv
// Bench for nonrd_div_param: directed cases plus randomized operations against an arithmetic model.
// Signed cases are exercised when NRD_SIGNED_EN is defined.
module tb_nonrd_div_param;
    localparam int W     = 16;
    localparam int LIMIT = 200;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
        int           lat;
    } res_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    nonrd_div_param_if #(.WIDTH(W)) bus ();

    nonrd_div_param #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                   input logic [W-1:0] m, input logic sg);
        res_t         res;
        logic         dn, mn;
        logic [2*W-1:0] d, dm, mm, qq, rr, half;
        d    = {hi, lo};
`ifdef NRD_SIGNED_EN
        dn   = sg & hi[W-1];
        mn   = sg & m[W-1];
`else
        dn   = 1'b0;
        mn   = 1'b0;
        if (sg) dn = 1'b0;
`endif
        dm   = dn ? -d : d;
        mm   = {{W{1'b0}}, (mn ? -m : m)};
        half = '0;
        half[W-1] = 1'b1;
        res.dbz = 1'b0;
        res.ovf = 1'b0;
        res.lat = W + 3;
        if (m == '0) begin
            res.dbz = 1'b1;
            res.q   = '1;
            res.r   = lo;
            res.lat = 2;
        end else if ({{W{1'b0}}, dm[2*W-1:W]} >= mm) begin
            res.ovf = 1'b1;
            res.q   = '1;
            res.r   = '0;
            res.lat = 2;
        end else begin
            qq = dm / mm;
            rr = dm % mm;
            res.r = dn ? -rr[W-1:0] : rr[W-1:0];
            if (dn ^ mn) begin
                res.q = -qq[W-1:0];
                if (qq > half) res.ovf = 1'b1;
            end else begin
                res.q = qq[W-1:0];
                if (sg && (dn | mn | 1'b1) && (qq >= half) && (dn | mn | sg_en())) res.ovf = 1'b1;
            end
            if (res.ovf) begin
                res.q = '1;
                res.r = '0;
            end
        end
        return res;
    endfunction

    function automatic logic sg_en();
`ifdef NRD_SIGNED_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    task automatic send_word(input string name, input logic [W-1:0] w, input logic sg);
        int n;
        bus.in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        bus.inbus       = w;
        bus.signed_mode = sg;
        bus.in_valid    = 1'b1;
        n = 0;
        while (!bus.in_ready && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        if (n >= LIMIT) chk({name, "_in_ready_timeout"}, 64'(n), 64'(0));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.inbus    = W'($urandom);
    endtask

    task automatic run_op(input string name, input logic [W-1:0] hi, input logic [W-1:0] lo,
                          input logic [W-1:0] m, input logic sg, input int stall);
        res_t e;
        int   lat;
        e = model(hi, lo, m, sg);
        send_word(name, hi, sg);
        send_word(name, lo, ~sg);
        send_word(name, m, ~sg);
        chk({name, "_in_ready_busy"}, 64'(bus.in_ready), 64'(0));
        chk({name, "_busy"}, 64'(bus.busy), 64'(1));
        lat = 0;
        while (!bus.out_valid && lat < LIMIT) begin
            bus.in_valid = 1'($urandom);
            bus.inbus    = W'($urandom);
            @(negedge clk);
            lat++;
        end
        bus.in_valid = 1'b0;
        chk({name, "_latency"}, 64'(lat), 64'(e.lat));
        bus.out_ready = 1'b0;
        repeat (stall) @(negedge clk);
        chk({name, "_q"}, 64'(bus.outbus), 64'(e.q));
        chk({name, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
        chk({name, "_ovf"}, 64'(bus.overflow), 64'(e.ovf));
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_r_valid"}, 64'(bus.out_valid), 64'(1));
        chk({name, "_r"}, 64'(bus.outbus), 64'(e.r));
        chk({name, "_r_ovf"}, 64'(bus.overflow), 64'(e.ovf));
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, "_done_valid"}, 64'(bus.out_valid), 64'(0));
        chk({name, "_done_busy"}, 64'(bus.busy), 64'(0));
        chk({name, "_done_outbus"}, 64'(bus.outbus), 64'(0));
        $display("op %s: %h_%h / %h signed=%0b -> q=%h r=%h dbz=%0b ovf=%0b lat=%0d",
                 name, hi, lo, m, sg, e.q, e.r, e.dbz, e.ovf, lat);
    endtask

    task automatic chk_reset_values(input string name);
        chk({name, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        chk({name, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        chk({name, "_outbus"}, 64'(bus.outbus), 64'(0));
        chk({name, "_busy"}, 64'(bus.busy), 64'(0));
        chk({name, "_dbz"}, 64'(bus.div_by_zero), 64'(0));
        chk({name, "_ovf"}, 64'(bus.overflow), 64'(0));
    endtask

    initial begin
        logic [W-1:0] hi, lo, m;
        int           sel;
        bus.inbus       = '0;
        bus.in_valid    = 1'b0;
        bus.signed_mode = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_values("reset");
        rst = 1'b0;
        @(negedge clk);

        run_op("t_16_2", 16'h0000, 16'h0010, 16'h0002, 1'b0, 0);
        run_op("t_1000_7", 16'h0000, 16'h03E8, 16'h0007, 1'b0, 5);
`ifdef NRD_SIGNED_EN
        run_op("s_m7_2", 16'hFFFF, 16'hFFF9, 16'h0002, 1'b1, 0);
        run_op("s_ovf", 16'hFFFF, 16'h8000, 16'hFFFF, 1'b1, 1);
`endif
        run_op("dbz", 16'h0001, 16'h2345, 16'h0000, 1'b0, 0);
        run_op("u_ovf", 16'h0002, 16'h0000, 16'h0001, 1'b0, 1);

        // Reset in the middle of an iteration, then a clean operation.
        send_word("rst_mid", 16'h0000, 1'b0);
        send_word("rst_mid", 16'h03E8, 1'b0);
        send_word("rst_mid", 16'h0007, 1'b0);
        repeat (7) @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_values("rst_mid");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op("after_rst", 16'h0000, 16'h0064, 16'h000A, 1'b0, 0);

        for (int i = 0; i < 200; i++) begin
            hi  = W'($urandom);
            lo  = W'($urandom);
            m   = W'($urandom);
            sel = $urandom_range(0, 15);
            if (sel == 0) m = '0;
            else if (sel < 12 && m != '0) hi = W'($urandom % 32'(m));
            run_op($sformatf("rnd%0d", i), hi, lo, m, 1'($urandom), $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
